// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//
// Contents:
//   state_t        responder FSM states (IDLE / WAIT / RESP)
//   MMIO_OUT_ADDR  byte address of the read/write I/O output register
//   MMIO_CNT_ADDR  byte address of the read-only free-running cycle counter
//   ERR_RDATA      load data returned by a rejected access
//   is_word_aligned  helper: true when the low two address bits are zero

package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [31:0] MMIO_OUT_ADDR = 32'hFFFF_FF00;
    localparam logic [31:0] MMIO_CNT_ADDR = 32'hFFFF_FF04;
    localparam logic [31:0] ERR_RDATA     = 32'h0000_0000;

    function automatic logic is_word_aligned(input logic [31:0] a);
        return (a[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/ram_sp.sv
// Single-port word RAM: synchronous write, asynchronous read.
// Contents are not reset.
//
// Parameters:
//   DEPTH  number of 32-bit words (power of two)
// Ports:
//   clk    clock, write on rising edge
//   we     write enable
//   addr   word index, shared by read and write
//   wdata  write data
//   rdata  read data, combinational from addr

module ram_sp #(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the multicycle core's load/store bus.
// A held request is captured in IDLE, WAIT wait states are inserted, and
// the access completes with a one-cycle ack carrying load data or err.
//
// Optional feature: define DMEM_MMIO_EN to decode two I/O addresses
// (output register at MMIO_OUT_ADDR, cycle counter at MMIO_CNT_ADDR).
// Without it both addresses are rejected and mmio_out is tied to 0.
//
// Handshake: the requester raises req with we/addr/wdata and holds all of
// them stable until ack. ack is a single-cycle pulse; err is only ever
// high together with ack. A req still high in the cycle after ack is
// taken as a new access.
//
// Parameters:
//   DEPTH  RAM size in 32-bit words (power of two, 4..4096)
//   WAIT   wait cycles before the response (0..15)
// Ports:
//   clk       clock
//   reset     synchronous, active-high
//   req       access request
//   we        1 = store word, 0 = load word
//   addr      byte address
//   wdata     store data
//   rdata     load data, valid in the ack cycle
//   ack       completion pulse
//   err       access rejected (with ack only)
//   busy      high while in WAIT or RESP
//   mmio_out  I/O output register

module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        busy,
    output logic [31:0] mmio_out
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT);

    state_t      state;
    logic [3:0]  cnt;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] rdata_q;

    logic [31:0] dec_addr;
    logic        dec_we;
    logic        hit_ram;
    logic        hit_out;
    logic        hit_cnt;
    logic        dec_err;
    logic        enter_resp;
    logic        leave_resp;
    logic        ram_we;
    logic [31:0] ram_rdata;
    logic [31:0] load_data;

`ifdef DMEM_MMIO_EN
    logic [31:0] mmio_q;
    logic [31:0] cycle_cnt;
`endif

    // With WAIT==0 the edge that captures the request is also the edge that
    // enters RESP, so in IDLE the decode looks at the live inputs (the values
    // being captured); everywhere else it uses the captured copy.
    always_comb begin
        dec_addr = (state == ST_IDLE) ? addr : addr_q;
        dec_we   = (state == ST_IDLE) ? we   : we_q;
        hit_ram  = is_word_aligned(dec_addr) && (dec_addr < RAM_BYTES);
`ifdef DMEM_MMIO_EN
        hit_out  = (dec_addr == MMIO_OUT_ADDR);
        hit_cnt  = (dec_addr == MMIO_CNT_ADDR);
`else
        hit_out  = 1'b0;
        hit_cnt  = 1'b0;
`endif
        dec_err  = !(hit_ram || hit_out || hit_cnt);
    end

    always_comb begin
`ifdef DMEM_MMIO_EN
        if (hit_ram) begin
            load_data = ram_rdata;
        end else if (hit_out) begin
            load_data = mmio_q;
        end else begin
            load_data = cycle_cnt;
        end
`else
        load_data = ram_rdata;
`endif
    end

    assign enter_resp = ((state == ST_IDLE) && req && (WAIT_INIT == 4'd0)) ||
                        ((state == ST_WAIT) && (cnt <= 4'd1));

    // Stores commit on the edge leaving RESP; a reset in that cycle wins.
    assign leave_resp = (state == ST_RESP) && !reset;
    assign ram_we     = leave_resp && we_q && !err_q && hit_ram;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        cnt     <= WAIT_INIT;
                        state   <= (WAIT_INIT == 4'd0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt <= 4'd1) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Response registers load on the edge entering RESP. A store leaves
    // rdata untouched unless it is rejected.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else if (enter_resp) begin
            err_q <= dec_err;
            if (dec_err) begin
                rdata_q <= ERR_RDATA;
            end else if (!dec_we) begin
                rdata_q <= load_data;
            end
        end
    end

`ifdef DMEM_MMIO_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            mmio_q    <= 32'd0;
            cycle_cnt <= 32'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (leave_resp && we_q && !err_q && hit_out) begin
                mmio_q <= wdata_q;
            end
        end
    end

    assign mmio_out = mmio_q;
`else
    assign mmio_out = 32'd0;
`endif

    ram_sp #(
        .DEPTH(DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (dec_addr[2 +: AW]),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    assign ack   = (state == ST_RESP) && !reset;
    assign err   = ack && err_q;
    assign busy  = (state != ST_IDLE);
    assign rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder. Three instances share one clock:
//   index 0: WAIT=2, index 1: WAIT=0, index 2: WAIT=1 (all DEPTH=64).
// A transaction-level model predicts ack/busy/err/rdata/mmio_out for every
// cycle; directed accesses add hand-computed literal expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.

module tb_dmem_responder;

    localparam int DEPTH = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset    [3];
    logic        req      [3];
    logic        we       [3];
    logic [31:0] addr     [3];
    logic [31:0] wdata    [3];
    logic [31:0] rdata    [3];
    logic        ack      [3];
    logic        err      [3];
    logic        busy     [3];
    logic [31:0] mmio_out [3];

    dmem_responder #(.DEPTH(DEPTH), .WAIT(2)) u_w2 (
        .clk(clk), .reset(reset[0]), .req(req[0]), .we(we[0]), .addr(addr[0]),
        .wdata(wdata[0]), .rdata(rdata[0]), .ack(ack[0]), .err(err[0]),
        .busy(busy[0]), .mmio_out(mmio_out[0])
    );
    dmem_responder #(.DEPTH(DEPTH), .WAIT(0)) u_w0 (
        .clk(clk), .reset(reset[1]), .req(req[1]), .we(we[1]), .addr(addr[1]),
        .wdata(wdata[1]), .rdata(rdata[1]), .ack(ack[1]), .err(err[1]),
        .busy(busy[1]), .mmio_out(mmio_out[1])
    );
    dmem_responder #(.DEPTH(DEPTH), .WAIT(1)) u_w1 (
        .clk(clk), .reset(reset[2]), .req(req[2]), .we(we[2]), .addr(addr[2]),
        .wdata(wdata[2]), .rdata(rdata[2]), .ack(ack[2]), .err(err[2]),
        .busy(busy[2]), .mmio_out(mmio_out[2])
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int w_of(input int i);
        case (i)
            0:       return 2;
            1:       return 0;
            default: return 1;
        endcase
    endfunction

    function automatic bit mmio_en();
`ifdef DMEM_MMIO_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // ---------------- behavioural model ----------------
    // An access accepted in cycle s acks in cycle s+W+1; busy covers
    // s+1..s+W+1; the next access can be accepted from cycle s+W+2.
    bit          act_m   [3];
    int          start_m [3];
    int          free_m  [3];
    int          cbase_m [3];
    bit          err_m   [3];
    bit          we_m    [3];
    logic [31:0] addr_m  [3];
    logic [31:0] wd_m    [3];
    logic [31:0] res_m   [3];
    bit          resv_m  [3];
    logic [31:0] last_m  [3];
    bit          lastv_m [3];
    logic [31:0] mmio_m  [3];
    logic [31:0] mem_m   [3][DEPTH];
    bit          memv_m  [3][DEPTH];
    int          cyc = 0;

    initial begin
        for (int i = 0; i < 3; i++) begin
            act_m[i] = 0; free_m[i] = 0; cbase_m[i] = 0;
            last_m[i] = 32'd0; lastv_m[i] = 1; mmio_m[i] = 32'd0;
            for (int k = 0; k < DEPTH; k++) memv_m[i][k] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                automatic int w;
                automatic bit e_ack;
                automatic bit e_busy;
                automatic logic [31:0] a;
                automatic bit io_out;
                automatic bit io_cnt;
                automatic bit in_ram;
                automatic int idx;
                w = w_of(i);
                e_ack  = act_m[i] && (cyc == start_m[i] + w + 1) && !reset[i];
                e_busy = act_m[i] && (cyc > start_m[i]) && (cyc <= start_m[i] + w + 1);
                check($sformatf("ack[%0d]@%0d", i, cyc), {31'd0, ack[i]}, {31'd0, e_ack});
                check($sformatf("busy[%0d]@%0d", i, cyc), {31'd0, busy[i]}, {31'd0, e_busy});
                check($sformatf("err[%0d]@%0d", i, cyc), {31'd0, err[i]}, {31'd0, e_ack && err_m[i]});
                check($sformatf("mmio_out[%0d]@%0d", i, cyc), mmio_out[i], mmio_m[i]);
                if (e_ack && resv_m[i])
                    check($sformatf("rdata[%0d]@%0d", i, cyc), rdata[i], res_m[i]);

                // advance the model with the inputs the next edge samples
                if (reset[i]) begin
                    act_m[i] = 0; free_m[i] = cyc + 1; cbase_m[i] = cyc + 1;
                    last_m[i] = 32'd0; lastv_m[i] = 1; mmio_m[i] = 32'd0;
                end else begin
                    if (act_m[i] && cyc == start_m[i] + w + 1) begin
                        if (!err_m[i] && we_m[i]) begin
                            if (addr_m[i] < 32'(DEPTH * 4)) begin
                                idx = int'((addr_m[i] >> 2) & 32'(DEPTH - 1));
                                mem_m[i][idx] = wd_m[i];
                                memv_m[i][idx] = 1;
                            end else if (addr_m[i] == 32'hFFFF_FF00) begin
                                mmio_m[i] = wd_m[i];
                            end
                        end
                        last_m[i] = res_m[i];
                        lastv_m[i] = resv_m[i];
                        act_m[i] = 0;
                    end
                    if (req[i] && cyc >= free_m[i]) begin
                        a = addr[i];
                        act_m[i] = 1; start_m[i] = cyc; free_m[i] = cyc + w + 2;
                        we_m[i] = we[i]; addr_m[i] = a; wd_m[i] = wdata[i];
                        in_ram = (a < 32'(DEPTH * 4));
                        io_out = mmio_en() && (a == 32'hFFFF_FF00);
                        io_cnt = mmio_en() && (a == 32'hFFFF_FF04);
                        err_m[i] = (a % 4 != 0) || !(in_ram || io_out || io_cnt);
                        if (err_m[i]) begin
                            res_m[i] = 32'd0; resv_m[i] = 1;
                        end else if (we[i]) begin
                            res_m[i] = last_m[i]; resv_m[i] = lastv_m[i];
                        end else if (in_ram) begin
                            idx = int'((a >> 2) & 32'(DEPTH - 1));
                            res_m[i] = mem_m[i][idx]; resv_m[i] = memv_m[i][idx];
                        end else if (io_out) begin
                            res_m[i] = mmio_m[i]; resv_m[i] = 1;
                        end else begin
                            res_m[i] = 32'(cyc + w - cbase_m[i]); resv_m[i] = 1;
                        end
                    end
                end
            end
            cyc++;
        end
    end

    // ---------------- driver ----------------
    task automatic do_access(input int i, input logic w_en, input logic [31:0] a,
                             input logic [31:0] d, output logic [31:0] rd,
                             output logic er, output int lat);
        bit got;
        @(posedge clk); #1;
        req[i] = 1'b1; we[i] = w_en; addr[i] = a; wdata[i] = d;
        lat = 0; got = 0; rd = 32'd0; er = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            if (ack[i]) begin
                got = 1; rd = rdata[i]; er = err[i];
            end else begin
                lat++;
            end
        end
        check($sformatf("ack_seen[%0d] addr %h", i, a), {31'd0, got}, 32'd1);
        @(posedge clk); #1;
        req[i] = 1'b0;
    endtask

    logic [31:0] rd, r1, r2;
    logic        er;
    int          lat, acks, run, maxrun;

    initial begin
        for (int i = 0; i < 3; i++) begin
            reset[i] = 1'b1; req[i] = 1'b0; we[i] = 1'b0;
            addr[i] = 32'd0; wdata[i] = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) reset[i] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset ack[%0d]", i), {31'd0, ack[i]}, 32'd0);
            check($sformatf("reset busy[%0d]", i), {31'd0, busy[i]}, 32'd0);
            check($sformatf("reset err[%0d]", i), {31'd0, err[i]}, 32'd0);
            check($sformatf("reset rdata[%0d]", i), rdata[i], 32'd0);
            check($sformatf("reset mmio_out[%0d]", i), mmio_out[i], 32'd0);
        end

        // WAIT=2 store then load of the same word
        do_access(0, 1'b1, 32'h10, 32'hCAFE_0001, rd, er, lat);
        check("w2 store latency", 32'(lat), 32'd3);
        check("w2 store err", {31'd0, er}, 32'd0);
        do_access(0, 1'b0, 32'h10, 32'd0, rd, er, lat);
        check("w2 load latency", 32'(lat), 32'd3);
        check("w2 load data", rd, 32'hCAFE_0001);
        check("w2 load err", {31'd0, er}, 32'd0);

        // WAIT=0: immediate response
        do_access(1, 1'b0, 32'h0, 32'd0, rd, er, lat);
        check("w0 load latency", 32'(lat), 32'd1);
        do_access(1, 1'b1, 32'h4, 32'hDEAD_BEEF, rd, er, lat);
        do_access(1, 1'b0, 32'h4, 32'd0, rd, er, lat);
        check("w0 load data", rd, 32'hDEAD_BEEF);

        // rejected accesses leave RAM untouched
        do_access(0, 1'b1, 32'h0, 32'h1111_2222, rd, er, lat);
        do_access(0, 1'b0, 32'h12, 32'd0, rd, er, lat);
        check("misaligned err", {31'd0, er}, 32'd1);
        check("misaligned rdata", rd, 32'd0);
        do_access(0, 1'b1, 32'h100, 32'h0000_0BAD, rd, er, lat);
        check("range err", {31'd0, er}, 32'd1);
        check("range rdata", rd, 32'd0);
        do_access(0, 1'b0, 32'h0, 32'd0, rd, er, lat);
        check("word0 unchanged", rd, 32'h1111_2222);
        check("word0 err", {31'd0, er}, 32'd0);

        // reset during WAIT abandons the store
        do_access(0, 1'b1, 32'h20, 32'h0BAD_F00D, rd, er, lat);
        @(posedge clk); #1;
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h1234_5678;
        @(posedge clk); #1;
        reset[0] = 1'b1; req[0] = 1'b0;
        @(posedge clk); #1;
        reset[0] = 1'b0;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack[0]) acks++;
        end
        check("abandoned ack count", 32'(acks), 32'd0);
        check("rdata after reset", rdata[0], 32'd0);
        do_access(0, 1'b0, 32'h20, 32'd0, rd, er, lat);
        check("abandoned store not written", {31'd0, rd == 32'h1234_5678}, 32'd0);
        check("old word kept", rd, 32'h0BAD_F00D);

        // WAIT=1 with req held high: ack every 3 cycles, single-cycle pulses
        do_access(2, 1'b1, 32'h8, 32'h5555_AAAA, rd, er, lat);
        @(posedge clk); #1;
        req[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h8;
        acks = 0; run = 0; maxrun = 0;
        repeat (9) begin
            @(negedge clk);
            if (ack[2]) begin
                acks++; run++;
                if (run > maxrun) maxrun = run;
                check("w1 streamed data", rdata[2], 32'h5555_AAAA);
            end else begin
                run = 0;
            end
        end
        check("w1 ack count", 32'(acks), 32'd3);
        check("w1 max pulse width", 32'(maxrun), 32'd1);
        @(posedge clk); #1;
        req[2] = 1'b0;
        repeat (4) @(posedge clk);

        // I/O region
`ifdef DMEM_MMIO_EN
        do_access(0, 1'b1, 32'hFFFF_FF00, 32'h0000_00A5, rd, er, lat);
        check("mmio store err", {31'd0, er}, 32'd0);
        @(negedge clk);
        check("mmio_out after store", mmio_out[0], 32'h0000_00A5);
        do_access(0, 1'b0, 32'hFFFF_FF00, 32'd0, rd, er, lat);
        check("mmio readback", rd, 32'h0000_00A5);
        do_access(0, 1'b0, 32'hFFFF_FF04, 32'd0, r1, er, lat);
        check("cnt load1 err", {31'd0, er}, 32'd0);
        do_access(0, 1'b0, 32'hFFFF_FF04, 32'd0, r2, er, lat);
        check("cnt load2 err", {31'd0, er}, 32'd0);
        check("cnt increasing", {31'd0, r2 > r1}, 32'd1);
        do_access(0, 1'b1, 32'hFFFF_FF04, 32'h0000_0077, rd, er, lat);
        check("cnt store err", {31'd0, er}, 32'd0);
`else
        do_access(0, 1'b0, 32'hFFFF_FF00, 32'd0, rd, er, lat);
        check("no-mmio out err", {31'd0, er}, 32'd1);
        check("no-mmio out rdata", rd, 32'd0);
        do_access(0, 1'b1, 32'hFFFF_FF04, 32'h0000_00A5, rd, er, lat);
        check("no-mmio cnt err", {31'd0, er}, 32'd1);
        @(negedge clk);
        check("no-mmio mmio_out", mmio_out[0], 32'd0);
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the processor's load/store bus. Accepts a held request (address, write enable, store data) from the core's memory stage, inserts a fixed number of wait states, then completes with a one-cycle acknowledge carrying load data or an error flag. Holds the word-addressed data RAM and, optionally, a small memory-mapped I/O region. It sits between the datapath's `aluout`/`writedata`/`readdata` signals and the stall logic of the multicycle core.

## Interface
- `DEPTH`, 64: RAM size in 32-bit words; power of two, 4..4096
- `WAIT`, 2: wait cycles inserted before the response, 0..15
- `clk`  in  1  single clock; all logic on the rising edge
- `reset`  in  1  synchronous, active-high
- `req`  in  1  access request; requester holds it and the inputs stable until `ack`
- `we`  in  1  1 = store word, 0 = load word
- `addr`  in  32  byte address
- `wdata`  in  32  store data
- `rdata`  out  32  load data; valid in the `ack` cycle
- `ack`  out  1  one-cycle completion pulse
- `err`  out  1  asserted only together with `ack`; access was rejected
- `busy`  out  1  high in WAIT and RESP
- `mmio_out`  out  32  I/O output register; constant 0 when the macro is absent

## Operation
- FSM states: IDLE, WAIT, RESP. Reset sends the FSM to IDLE.
- IDLE with `req` high:
  - Capture `we`, `addr` and `wdata` into internal registers.
  - Load the 4-bit wait counter with `WAIT`.
  - Go to WAIT. If `WAIT`==0, go straight to RESP.
- WAIT: decrement the counter each cycle. Go to RESP in the cycle the counter reaches 1.
- Register `rdata` and `err` on the edge that enters RESP.
- RESP: `ack`=1 for exactly one cycle. Stores commit on the edge that leaves RESP. The next state is always IDLE.
- Decode uses the captured address only:
  - `addr[1:0]` != 0 sets err.
  - An address at or above `DEPTH*4` that is not a decoded I/O address sets err.
  - Otherwise the RAM index is `addr[2 +: $clog2(DEPTH)]`.
- Error access: no write takes place, `rdata` = 32'h0000_0000, `err`=1.
- Load: `rdata` = the RAM word. Store: `rdata` keeps its previous value.
- Changes to `req` or the inputs after capture are ignored until the FSM returns to IDLE. A `req` still high in the cycle after `ack` starts a new access.

## Timing
- Latency: `req` sampled in IDLE at cycle 0, `ack` in cycle `WAIT`+1.
- Minimum access period is `WAIT`+2 cycles, because RESP always returns through IDLE.
- A load that follows a store to the same word sees the new data.
- Reset values: `ack`=0, `err`=0, `busy`=0, `rdata`=0, `mmio_out`=0, counter 0.
- RAM contents are not reset.
- Reset during WAIT or RESP abandons the access: no write, no `ack`.

## Configuration
- `DMEM_MMIO_EN` defined, two extra addresses are decoded:
  - 32'hFFFF_FF00: read/write I/O register that drives `mmio_out`; the write commits at the RESP exit edge.
  - 32'hFFFF_FF04: read-only free-running 32-bit cycle counter, cleared by reset. A store to it completes with `err`=0 and has no effect.
- `DMEM_MMIO_EN` undefined: both addresses report `err`, and `mmio_out` is tied to 0.

## Structure
- Package `dmem_pkg` holds:
  - the state enum typedef (IDLE/WAIT/RESP)
  - the constants `MMIO_OUT_ADDR` and `MMIO_CNT_ADDR`
  - the error-read constant `ERR_RDATA` = 32'h0
- One sub-module, `ram_sp`: a single-port word RAM with synchronous write and asynchronous read, parameterised by `DEPTH`.

## Test plan
- `WAIT`=2: store 32'hCAFE_0001 to 0x10, then load 0x10. Each `ack` arrives 3 cycles after `req`, `err`=0, and the load returns 32'hCAFE_0001.
- `WAIT`=0: load from 0x0 after reset. `ack` arrives in cycle 1, and `busy` is high only in that cycle.
- Load from 0x12 (misaligned), then store to 0x100 with `DEPTH`=64. Both complete with `err`=1 and `rdata`=0, and a later load from 0x0 is unchanged.
- Assert `reset` in the WAIT cycle of a store of 32'h1234_5678 to 0x20. No `ack` follows, and a later load from 0x20 does not return 32'h1234_5678.
- Hold `req` high continuously with `WAIT`=1. `ack` pulses every 3 cycles, and no pulse is ever longer than one cycle.
- With `DMEM_MMIO_EN`: store 32'hA5 to 0xFFFF_FF00, so `mmio_out`=32'hA5 from the cycle after `ack`. Two loads of 0xFFFF_FF04 return increasing values. Without the macro, both addresses return `err`=1.
